// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// =============================================================================
//  ttt_game_ctrl : tic-tac-toe game sequencer with board, turns, timeout, scores
//  Revision      : 1.0
// =============================================================================

module ticTacToeWin (
    input  logic [8:0] grid_marked,
    input  logic [8:0] grid_x,
    output logic       someone_won,
    output logic       player_x_won
);
    localparam logic [7:0][8:0] c_line_mask = {
        9'b111_000_000, 9'b000_111_000, 9'b000_000_111,
        9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
        9'b100_010_001, 9'b001_010_100
    };

    logic [7:0] w_x_line;
    logic [7:0] w_o_line;
    logic [8:0] w_grid_x;
    logic [8:0] w_grid_o;

    assign w_grid_x = grid_marked & grid_x;
    assign w_grid_o = grid_marked & ~grid_x;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_line
        assign w_x_line[gi] = (w_grid_x & c_line_mask[gi]) == c_line_mask[gi];
        assign w_o_line[gi] = (w_grid_o & c_line_mask[gi]) == c_line_mask[gi];
    end

    assign player_x_won = |w_x_line;
    assign someone_won  = (|w_x_line) | (|w_o_line);
endmodule

module ttt_game_ctrl #(
    parameter bit X_FIRST      = 1'b1,
    parameter int TURN_TIMEOUT = 64,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [3:0]         move_pos,
    output logic               move_ready,
    output logic               move_err,
    output logic [8:0]         grid_marked,
    output logic [8:0]         grid_x,
    output logic               turn_x,
    output logic               game_over,
    output logic               winner_x,
    output logic               winner_o,
    output logic               draw,
    output logic               forfeit,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] score_draw
);
    localparam int TIMER_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(TURN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [8:0]           grid_marked_q, grid_marked_d;
    logic [8:0]           grid_x_q, grid_x_d;
    logic                 turn_x_q, turn_x_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 move_err_q, move_err_d;
    logic                 winner_x_q, winner_x_d;
    logic                 winner_o_q, winner_o_d;
    logic                 draw_q, draw_d;
    logic                 forfeit_q, forfeit_d;
    logic [SCORE_W-1:0]   score_x_q, score_x_d;
    logic [SCORE_W-1:0]   score_o_q, score_o_d;
    logic [SCORE_W-1:0]   score_draw_q, score_draw_d;

    logic [8:0] w_sq;
    logic       w_legal;
    logic       w_someone_won;
    logic       w_player_x_won;

    ticTacToeWin u_win (
        .grid_marked  (grid_marked_q),
        .grid_x       (grid_x_q),
        .someone_won  (w_someone_won),
        .player_x_won (w_player_x_won)
    );

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    // Positions 9..15 shift out of the 9-bit vector, so w_sq is zero for them.
    assign w_sq    = 9'b1 << move_pos;
    assign w_legal = (move_pos <= 4'd8) && ((w_sq & grid_marked_q) == 9'b0);

    always_comb begin
        state_d       = state_q;
        grid_marked_d = grid_marked_q;
        grid_x_d      = grid_x_q;
        turn_x_d      = turn_x_q;
        timer_d       = timer_q;
        move_err_d    = 1'b0;
        winner_x_d    = winner_x_q;
        winner_o_d    = winner_o_q;
        draw_d        = draw_q;
        forfeit_d     = forfeit_q;
        score_x_d     = score_x_q;
        score_o_d     = score_o_q;
        score_draw_d  = score_draw_q;

        if (new_game) begin
            state_d       = S_TURN;
            grid_marked_d = 9'b0;
            grid_x_d      = 9'b0;
            turn_x_d      = X_FIRST;
            timer_d       = '0;
            winner_x_d    = 1'b0;
            winner_o_d    = 1'b0;
            draw_d        = 1'b0;
            forfeit_d     = 1'b0;
        end else begin
            case (state_q)
                S_TURN: begin
                    if (move_valid && w_legal) begin
                        grid_marked_d = grid_marked_q | w_sq;
                        grid_x_d      = grid_x_q | (turn_x_q ? w_sq : 9'b0);
                        state_d       = S_CHECK;
                    end else if ((TURN_TIMEOUT != 0) && (timer_q == c_timer_last)) begin
                        // Player to move forfeits; an illegal move here raises no error.
                        forfeit_d  = 1'b1;
                        winner_x_d = !turn_x_q;
                        winner_o_d = turn_x_q;
                        state_d    = S_DONE;
                        if (turn_x_q) score_o_d = sat_inc(score_o_q);
                        else          score_x_d = sat_inc(score_x_q);
                    end else begin
                        move_err_d = move_valid;
                        timer_d    = timer_q + TIMER_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_someone_won) begin
                        winner_x_d = w_player_x_won;
                        winner_o_d = !w_player_x_won;
                        state_d    = S_DONE;
                        if (w_player_x_won) score_x_d = sat_inc(score_x_q);
                        else                score_o_d = sat_inc(score_o_q);
                    end else if (grid_marked_q == 9'h1FF) begin
                        draw_d       = 1'b1;
                        state_d      = S_DONE;
                        score_draw_d = sat_inc(score_draw_q);
                    end else begin
                        turn_x_d = !turn_x_q;
                        timer_d  = '0;
                        state_d  = S_TURN;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grid_marked_q <= 9'b0;
            grid_x_q      <= 9'b0;
            turn_x_q      <= X_FIRST;
            timer_q       <= '0;
            move_err_q    <= 1'b0;
            winner_x_q    <= 1'b0;
            winner_o_q    <= 1'b0;
            draw_q        <= 1'b0;
            forfeit_q     <= 1'b0;
            score_x_q     <= '0;
            score_o_q     <= '0;
            score_draw_q  <= '0;
        end else begin
            state_q       <= state_d;
            grid_marked_q <= grid_marked_d;
            grid_x_q      <= grid_x_d;
            turn_x_q      <= turn_x_d;
            timer_q       <= timer_d;
            move_err_q    <= move_err_d;
            winner_x_q    <= winner_x_d;
            winner_o_q    <= winner_o_d;
            draw_q        <= draw_d;
            forfeit_q     <= forfeit_d;
            score_x_q     <= score_x_d;
            score_o_q     <= score_o_d;
            score_draw_q  <= score_draw_d;
        end
    end

    assign move_ready  = (state_q == S_TURN);
    assign game_over   = (state_q == S_DONE);
    assign move_err    = move_err_q;
    assign grid_marked = grid_marked_q;
    assign grid_x      = grid_x_q;
    assign turn_x      = turn_x_q;
    assign winner_x    = winner_x_q;
    assign winner_o    = winner_o_q;
    assign draw        = draw_q;
    assign forfeit     = forfeit_q;
    assign score_x     = score_x_q;
    assign score_o     = score_o_q;
    assign score_draw  = score_draw_q;
endmodule

`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// =============================================================================
//  tb_ttt_game_ctrl : randomized and directed checks against a board-level model
//  Revision         : 1.0
// =============================================================================
module tb_ttt_game_ctrl;
    localparam int TO = 4;
    localparam int SW = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          new_game = 1'b0;
    logic          move_valid = 1'b0;
    logic [3:0]    move_pos = 4'd0;
    logic          move_ready, move_err, turn_x, game_over;
    logic          winner_x, winner_o, draw, forfeit;
    logic [8:0]    grid_marked, grid_x;
    logic [SW-1:0] score_x, score_o, score_draw;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.X_FIRST(1'b1), .TURN_TIMEOUT(TO), .SCORE_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .move_err(move_err),
        .grid_marked(grid_marked), .grid_x(grid_x), .turn_x(turn_x),
        .game_over(game_over), .winner_x(winner_x), .winner_o(winner_o),
        .draw(draw), .forfeit(forfeit), .score_x(score_x), .score_o(score_o),
        .score_draw(score_draw)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: board squares hold 0 empty, 1 X, 2 O.
    int brd[9];
    bit m_tx, m_over, m_ready, m_wx, m_wo, m_draw, m_ff, m_err;
    int tel;
    int sx, so, sd;
    int lines[8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                        '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_marked();
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) v[i] = (brd[i] != 0);
        return v;
    endfunction

    function automatic logic [8:0] exp_x();
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) v[i] = (brd[i] == 1);
        return v;
    endfunction

    function automatic int line_owner();
        for (int l = 0; l < 8; l++)
            if (brd[lines[l][0]] != 0 && brd[lines[l][0]] == brd[lines[l][1]] &&
                brd[lines[l][1]] == brd[lines[l][2]])
                return brd[lines[l][0]];
        return 0;
    endfunction

    function automatic bit board_full();
        for (int i = 0; i < 9; i++) if (brd[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".marked"}, grid_marked, exp_marked());
        check_eq({tag, ".gx"},     grid_x,      exp_x());
        check_eq({tag, ".turn"},   turn_x,      m_tx);
        check_eq({tag, ".ready"},  move_ready,  m_ready);
        check_eq({tag, ".over"},   game_over,   m_over);
        check_eq({tag, ".err"},    move_err,    m_err);
        check_eq({tag, ".flags"},  {winner_x, winner_o, draw, forfeit}, {m_wx, m_wo, m_draw, m_ff});
        check_eq({tag, ".scores"}, {score_x, score_o, score_draw}, {sx[SW-1:0], so[SW-1:0], sd[SW-1:0]});
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) brd[i] = 0;
        m_tx = 1'b1; {m_over, m_ready, m_wx, m_wo, m_draw, m_ff, m_err} = '0;
        tel = 0; sx = 0; so = 0; sd = 0;
    endtask

    // who: 1 = X wins, 2 = O wins, 3 = draw
    task automatic end_game(input int who, input bit ff);
        m_over = 1'b1; m_ready = 1'b0; m_ff = ff;
        m_wx = (who == 1); m_wo = (who == 2); m_draw = (who == 3);
        if (who == 1 && sx < SMAX) sx++;
        if (who == 2 && so < SMAX) so++;
        if (who == 3 && sd < SMAX) sd++;
    endtask

    task automatic start_game(input bit with_move);
        move_valid = with_move;
        move_pos   = 4'($urandom_range(0, 8));
        new_game   = 1'b1;
        clk_step();
        new_game = 1'b0; move_valid = 1'b0;
        for (int i = 0; i < 9; i++) brd[i] = 0;
        m_tx = 1'b1; m_ready = 1'b1; tel = 0;
        {m_over, m_wx, m_wo, m_draw, m_ff, m_err} = '0;
        check_all("new");
    endtask

    task automatic nolegal_edge(input bit was_illegal);
        tel++;
        if (tel == TO) begin
            end_game(m_tx ? 2 : 1, 1'b1);
            m_err = 1'b0;
        end else begin
            m_err = was_illegal;
        end
    endtask

    // Present a move only (leaves the DUT in its evaluation cycle if legal).
    task automatic move_only(input int pos, output bit legal);
        move_valid = 1'b1; move_pos = pos[3:0];
        clk_step();
        move_valid = 1'b0;
        legal = (pos <= 8);
        if (legal) legal = (brd[pos] == 0);
        if (legal) begin
            brd[pos] = m_tx ? 1 : 2;
            m_ready = 1'b0; m_err = 1'b0;
            check_all("move");
        end else begin
            nolegal_edge(1'b1);
            check_all("bad");
        end
    endtask

    task automatic turn(input int pos, input int idle);
        bit legal;
        int w;
        if (m_over) return;
        for (int k = 0; k < idle && !m_over; k++) begin
            move_valid = 1'b0;
            clk_step();
            nolegal_edge(1'b0);
            check_all("idle");
        end
        if (m_over) return;
        move_only(pos, legal);
        if (legal) begin
            clk_step();
            m_err = 1'b0;
            w = line_owner();
            if (w != 0)            end_game(w, 1'b0);
            else if (board_full()) end_game(3, 1'b0);
            else begin m_tx = !m_tx; m_ready = 1'b1; tel = 0; end
            check_all("eval");
        end
    endtask

    task automatic play(input int seq[$]);
        foreach (seq[i]) turn(seq[i], 0);
    endtask

    int pos, idle;
    bit lg;

    initial begin
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;
        move_valid = 1'b1; move_pos = 4'd0;
        clk_step();
        move_valid = 1'b0;
        check_all("idle_ignore");

        start_game(1'b0);
        play('{8, 5, 7, 4});
        turn(6, 0);
        check_eq("g1.gx",  grid_x, 9'b111_000_000);
        check_eq("g1.mk",  grid_marked, 9'b111_110_000);
        check_eq("g1.wx",  winner_x, 1'b1);
        check_eq("g1.sx",  score_x, 8'd1);

        move_valid = 1'b1; move_pos = 4'd0;
        clk_step();
        move_valid = 1'b0;
        check_all("done_ignore");

        start_game(1'b0);
        play('{8, 2, 5, 1, 3, 0});
        check_eq("g2.wo", winner_o, 1'b1);
        check_eq("g2.gx", grid_x, 9'b100_101_000);

        start_game(1'b0);
        play('{8, 7, 6, 3, 4, 2, 5, 0, 1});
        check_eq("draw.mk", grid_marked, 9'h1FF);
        check_eq("draw.gx", grid_x, 9'b101_110_010);
        check_eq("draw.f",  draw, 1'b1);
        check_eq("draw.sd", score_draw, 8'd1);

        start_game(1'b0);
        turn(4, 0);
        turn(4, 0);
        check_eq("ill.err1", move_err, 1'b1);
        turn(9, 0);
        check_eq("ill.err2", move_err, 1'b1);
        check_eq("ill.turn", turn_x, 1'b0);

        start_game(1'b0);
        turn(0, TO);
        check_eq("to.ff", forfeit, 1'b1);
        check_eq("to.wo", winner_o, 1'b1);

        start_game(1'b0);
        turn(0, TO - 1);
        check_eq("to4.ff", forfeit, 1'b0);
        check_eq("to4.mk", grid_marked, 9'b000_000_001);

        start_game(1'b0);
        turn(0, 0);
        turn(1, 0);
        start_game(1'b1);
        move_only(4, lg);
        start_game(1'b0);

        move_only(2, lg);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_check");
        #3 reset_n = 1'b1;

        for (int g = 0; g < 300; g++) begin
            start_game(1'b0);
            play('{8, 5, 7, 4, 6});
        end
        check_eq("sat.sx", score_x, 8'd255);

        for (int g = 0; g < 60; g++) begin
            start_game(1'b0);
            for (int n = 0; n < 40 && !m_over; n++) begin
                if ($urandom_range(0, 29) == 0) start_game($urandom_range(0, 1) == 1);
                pos = $urandom_range(0, 10);
                if ($urandom_range(0, 9) < 7) begin
                    for (int t = 0; t < 20; t++) begin
                        pos = $urandom_range(0, 8);
                        if (brd[pos] == 0) break;
                    end
                end
                idle = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
                turn(pos, idle);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
